mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from request acceptance to response pulse; legal range 1..255.
REQ-002 Parameter LG_DEPTH, default 12: log2 of backing-store depth in L2 lines.
REQ-003 clk  input  1  single clock; all state is updated on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_req_valid  input  1  request level from the L2; held high until a response is seen.
REQ-006 mem_req_addr  input  M_WIDTH  byte address, line aligned.
REQ-007 mem_req_opcode  input  4  4 = load (MEM_LW), 7 = store (MEM_SW).
REQ-008 mem_req_store_data  input  1<<(LG_L2_CL_LEN+3)  line write data.
REQ-009 mem_rsp_valid  output  1  one-cycle response pulse.
REQ-010 mem_rsp_load_data  output  1<<(LG_L2_CL_LEN+3)  line read data.
REQ-011 load_count, store_count  output  64 each  completed-transaction counters.

Function
REQ-012 Line index = mem_req_addr[LG_L2_CL_LEN+LG_DEPTH-1 : LG_L2_CL_LEN]; bits above and below the index are ignored, so addresses wrap modulo the depth.
REQ-013 The FSM has four states, IDLE, BUSY, RESPOND and DRAIN; all outputs are registered.
REQ-014 IDLE transitions:
- mem_req_valid=1 in cycle T: capture address, opcode and store data; load the latency counter with LATENCY-1; go to BUSY.
- If LATENCY=1: go directly to RESPOND.
REQ-015 BUSY decrements the counter each cycle and goes to RESPOND when the counter reaches 0, so mem_rsp_valid is high in cycle T+LATENCY.
REQ-016 RESPOND behaviour:
- Drive mem_rsp_valid=1 for exactly one cycle.
- Load: mem_rsp_load_data = RAM[index], valid in the same cycle.
- Store: write the captured data to RAM[index] at the end of the cycle.
- Then go to DRAIN.
REQ-017 DRAIN lasts exactly one cycle, ignores mem_req_valid (the L2 drops its request that cycle), then returns to IDLE.
REQ-018 mem_req_valid high in IDLE after DRAIN is a new request, including back-to-back store-then-load turnaround.
REQ-019 mem_rsp_load_data holds its last load value through store responses and idle periods; it changes only on a load response.
REQ-020 Captured request fields are frozen from acceptance; input changes during BUSY/RESPOND have no effect.
REQ-021 Opcodes other than 4 and 7 still produce a response pulse at the same latency, with no RAM write, no change to mem_rsp_load_data and no counter increment.
REQ-022 A load to an index written by an earlier store returns that store's data (read-after-write ordering follows request order).
REQ-023 load_count or store_count increments by 1 in the RESPOND cycle; both wrap at 2^64.

Reset
REQ-024 Reset asserted: state=IDLE, mem_rsp_valid=0, mem_rsp_load_data=0, load_count=0, store_count=0, latency counter=0, LFSR=16'hACE1.
REQ-025 Reset asserted mid-transaction aborts it: no response pulse, no RAM write, no counter increment.
REQ-026 RAM contents are not reset.

Configuration
REQ-027 Macro MEM_RSP_RANDOM_LAT_EN defined:
- A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances once per accepted request.
- Its low 3 bits are added to LATENCY, giving latency LATENCY..LATENCY+7.
REQ-028 Macro MEM_RSP_RANDOM_LAT_EN undefined: no LFSR logic; latency is exactly LATENCY.

Verification
REQ-029 LATENCY=4; store 7 to addr 0x40 with data 128'h1111...; req held until rsp -> rsp pulse exactly 4 cycles after acceptance, store_count=1.
REQ-030 Then load from 0x40 after the 1-cycle drop -> rsp 4 cycles later, load_data=128'h1111..., load_count=1.
REQ-031 LG_DEPTH=12; store to 0x40, then load 0x40+(1<<(12+LG_L2_CL_LEN)) -> same data returned (index wrap).
REQ-032 Load accepted, reset pulsed during BUSY -> no rsp pulse, counters 0, mem_rsp_load_data 0; a subsequent load completes normally.
REQ-033 Opcode 3 request -> single rsp pulse at LATENCY, RAM unchanged, both counters unchanged.
REQ-034 MEM_RSP_RANDOM_LAT_EN defined, 32 loads -> every latency within 4..11, sequence identical across two runs.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder -- behavioural main-memory model answering line requests
// from an L2 cache with a fixed (or optionally jittered) latency.
//
// Parameters:
//   LATENCY       cycles from request acceptance to the response pulse (1..255)
//   LG_DEPTH      log2 of the backing-store depth in L2 lines
//   M_WIDTH       byte-address width
//   LG_L2_CL_LEN  log2 of the line length in bytes (line = 1<<(LG_L2_CL_LEN+3) bits)
//
// Ports:
//   clk                 single clock, all state updates on posedge
//   reset               asynchronous, active-high reset
//   mem_req_valid       request level, held by the L2 until it sees a response
//   mem_req_addr        line-aligned byte address
//   mem_req_opcode      4 = load, 7 = store, anything else = no-op response
//   mem_req_store_data  line write data
//   mem_rsp_valid       one-cycle response pulse
//   mem_rsp_load_data   line read data, changes only on a load response
//   load_count          completed loads (wraps at 2^64)
//   store_count         completed stores (wraps at 2^64)
//   o_dbg_state         current FSM state, for observation only
//
// Build option: defining MEM_RSP_RANDOM_LAT_EN adds a 16-bit LFSR whose low
// three bits stretch each request's latency to LATENCY..LATENCY+7.
//
// Handshake: there is no ready signal. A request is accepted on the first
// posedge at which mem_req_valid is high while the FSM is idle; its address,
// opcode and data are captured then and frozen. The L2 keeps valid high until
// it sees mem_rsp_valid, then drops it for at least the one drain cycle that
// follows the response, during which valid is ignored.

module mem_responder #(
  parameter int LATENCY      = 4,
  parameter int LG_DEPTH     = 12,
  parameter int M_WIDTH      = 32,
  parameter int LG_L2_CL_LEN = 4,
  localparam int DW          = 1 << (LG_L2_CL_LEN + 3)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_req_valid,
  input  logic [M_WIDTH-1:0] mem_req_addr,
  input  logic [3:0]         mem_req_opcode,
  input  logic [DW-1:0]      mem_req_store_data,
  output logic               mem_rsp_valid,
  output logic [DW-1:0]      mem_rsp_load_data,
  output logic [63:0]        load_count,
  output logic [63:0]        store_count,
  output logic [1:0]         o_dbg_state
);

  localparam int CW     = 9;  // holds LATENCY-1 plus up to 7 cycles of jitter
  localparam int IDX_LO = LG_L2_CL_LEN;
  localparam int IDX_HI = LG_L2_CL_LEN + LG_DEPTH - 1;
  localparam int DEPTH  = 1 << LG_DEPTH;

  localparam logic [3:0] OP_LW = 4'd4;
  localparam logic [3:0] OP_SW = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RESPOND = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_next;
  logic [CW-1:0]         w_lat_m1;

  logic [LG_DEPTH-1:0]   r_idx;
  logic [3:0]            r_op;
  logic [DW-1:0]         r_data;

  logic                  r_rsp_valid;
  logic [DW-1:0]         r_load_data;
  logic [63:0]           r_load_count;
  logic [63:0]           r_store_count;

  logic [DW-1:0]         r_mem [0:DEPTH-1];

  logic                  w_accept;
  logic                  w_enter_rsp;
  logic [LG_DEPTH-1:0]   w_req_idx;
  logic [LG_DEPTH-1:0]   w_idx_eff;
  logic [3:0]            w_op_eff;
  logic                  w_unused;

  assign w_req_idx = mem_req_addr[IDX_HI:IDX_LO];
  assign w_accept  = (r_state == S_IDLE) && mem_req_valid;

  // Address bits outside the line index are deliberately ignored.
  assign w_unused = ^{mem_req_addr[M_WIDTH-1:IDX_HI+1], mem_req_addr[IDX_LO-1:0]};

`ifdef MEM_RSP_RANDOM_LAT_EN
  // Fibonacci LFSR, taps 16,14,13,11. The jitter for a request comes from the
  // value held when it is accepted; the register then advances once.
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lat_m1  = CW'(LATENCY - 1) + {{(CW-3){1'b0}}, r_lfsr[2:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end
`else
  assign w_lat_m1 = CW'(LATENCY - 1);
`endif

  // A response can start straight from IDLE (total latency 1), when the
  // captured registers are not loaded yet, so use the live inputs there.
  assign w_op_eff  = (r_state == S_IDLE) ? mem_req_opcode : r_op;
  assign w_idx_eff = (r_state == S_IDLE) ? w_req_idx      : r_idx;

  // Next-state and counter logic.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (mem_req_valid) begin
          if (w_lat_m1 == '0) begin
            w_next     = S_RESPOND;
            w_cnt_next = '0;
          end else begin
            w_next     = S_BUSY;
            w_cnt_next = w_lat_m1;
          end
        end
      end
      S_BUSY: begin
        // Leaving on the edge where the counter steps 1 -> 0 places the
        // RESPOND cycle exactly LATENCY cycles after acceptance.
        w_cnt_next = r_cnt - {{(CW-1){1'b0}}, 1'b1};
        if (r_cnt <= {{(CW-1){1'b0}}, 1'b1}) begin
          w_next     = S_RESPOND;
          w_cnt_next = '0;
        end
      end
      S_RESPOND: w_next = S_DRAIN;
      S_DRAIN:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Response outputs are registered on the edge that enters RESPOND so they
  // are valid throughout the RESPOND cycle.
  assign w_enter_rsp = (w_next == S_RESPOND) && (r_state != S_RESPOND);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_op          <= '0;
      r_data        <= '0;
      r_rsp_valid   <= 1'b0;
      r_load_data   <= '0;
      r_load_count  <= '0;
      r_store_count <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_rsp_valid <= w_enter_rsp;
      if (w_accept) begin
        r_idx  <= w_req_idx;
        r_op   <= mem_req_opcode;
        r_data <= mem_req_store_data;
      end
      if (w_enter_rsp) begin
        if (w_op_eff == OP_LW) begin
          r_load_data  <= r_mem[w_idx_eff];
          r_load_count <= r_load_count + 64'd1;
        end
        if (w_op_eff == OP_SW) begin
          r_store_count <= r_store_count + 64'd1;
        end
      end
    end
  end

  // Backing store, not reset. A store lands at the end of its RESPOND cycle;
  // an asynchronous reset in flight moves the FSM out of RESPOND first, so an
  // aborted store never writes.
  always_ff @(posedge clk) begin
    if ((r_state == S_RESPOND) && (r_op == OP_SW)) begin
      r_mem[r_idx] <= r_data;
    end
  end

  assign mem_rsp_valid     = r_rsp_valid;
  assign mem_rsp_load_data = r_load_data;
  assign load_count        = r_load_count;
  assign store_count       = r_store_count;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder -- self-checking bench for mem_responder with default
// parameters (LATENCY=4, LG_DEPTH=12, 32-bit addresses, 128-bit lines).
// A reference model (associative array of lines, expected counters and the
// last load value) is updated per request in request order.

module tb_mem_responder;

  localparam int LAT      = 4;
  localparam int LG_DEPTH = 12;
  localparam int LG_CL    = 4;
  localparam int DW       = 128;
  localparam int AW       = 32;
  localparam int TIMEOUT  = 300;

  logic          clk;
  logic          reset;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic [3:0]    mem_req_opcode;
  logic [DW-1:0] mem_req_store_data;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_load_data;
  logic [63:0]   load_count;
  logic [63:0]   store_count;
  logic [1:0]    o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_last_load;
  logic [63:0]   exp_ld_cnt;
  logic [63:0]   exp_st_cnt;

  mem_responder #(
    .LATENCY      (LAT),
    .LG_DEPTH     (LG_DEPTH),
    .M_WIDTH      (AW),
    .LG_L2_CL_LEN (LG_CL)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .mem_req_valid      (mem_req_valid),
    .mem_req_addr       (mem_req_addr),
    .mem_req_opcode     (mem_req_opcode),
    .mem_req_store_data (mem_req_store_data),
    .mem_rsp_valid      (mem_rsp_valid),
    .mem_rsp_load_data  (mem_rsp_load_data),
    .load_count         (load_count),
    .store_count        (store_count),
    .o_dbg_state        (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers (stimulus and model only) ----------------
  function automatic logic [DW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [AW-1:0] mk_addr(input int idx);
    logic [AW-1:0] hi;
    hi = AW'($urandom_range(0, 65535));
    return (hi << (LG_CL + LG_DEPTH)) | (AW'(idx) << LG_CL);
  endfunction

  function automatic int idx_of(input logic [AW-1:0] addr);
    return int'((addr >> LG_CL) % (1 << LG_DEPTH));
  endfunction

  function automatic bit lat_ok(input int lat);
`ifdef MEM_RSP_RANDOM_LAT_EN
    return (lat >= LAT) && (lat <= LAT + 7);
`else
    return lat == LAT;
`endif
  endfunction

  // Apply one request to the model in request order.
  task automatic model_apply(input logic [3:0] op, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data);
    if (op == 4'd7) begin
      model_mem[idx_of(addr)] = data;
      exp_st_cnt = exp_st_cnt + 64'd1;
    end else if (op == 4'd4) begin
      exp_last_load = model_mem[idx_of(addr)];
      exp_q.push_back(exp_last_load);
      exp_ld_cnt = exp_ld_cnt + 64'd1;
    end
  endtask

  task automatic model_reset();
    exp_last_load = '0;
    exp_ld_cnt    = '0;
    exp_st_cnt    = '0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // Called at a negedge in an idle cycle. Holds valid until the response,
  // scrambles the request inputs after acceptance, drops valid, checks the
  // drain cycle and returns at the negedge of the next idle cycle.
  task automatic drive_txn(input logic [3:0] op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, output int lat,
                           output logic [DW-1:0] rdata, output bit single);
    lat    = 0;
    rdata  = '0;
    single = 1'b0;
    mem_req_valid      = 1'b1;
    mem_req_opcode     = op;
    mem_req_addr       = addr;
    mem_req_store_data = data;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mem_req_addr       = $urandom;
        mem_req_opcode     = 4'($urandom_range(0, 15));
        mem_req_store_data = rand_line();
      end
      if (mem_rsp_valid) begin
        lat   = k;
        rdata = mem_rsp_load_data;
        break;
      end
    end
    mem_req_valid = 1'b0;
    @(negedge clk);
    single = (lat != 0) && !mem_rsp_valid;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    mem_req_valid      = 1'b0;
    mem_req_addr       = '0;
    mem_req_opcode     = '0;
    mem_req_store_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (mem_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", mem_rsp_valid); end
    n_tests++; if (mem_rsp_load_data !== '0) begin n_fail++; $display("FAIL reset_load_data got=%h exp=0", mem_rsp_load_data); end
    n_tests++; if (load_count !== 64'd0) begin n_fail++; $display("FAIL reset_load_count got=%0d exp=0", load_count); end
    n_tests++; if (store_count !== 64'd0) begin n_fail++; $display("FAIL reset_store_count got=%0d exp=0", store_count); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    int lat; logic [DW-1:0] rd; bit single;
    logic [DW-1:0] d;
    d = {8{16'h1111}};
    model_apply(4'd7, 32'h40, d);
    drive_txn(4'd7, 32'h40, d, lat, rd, single);
    n_tests++; if (!lat_ok(lat)) begin n_fail++; $display("FAIL sl_store_latency got=%0d exp=%0d", lat, LAT); end
    n_tests++; if (!single) begin n_fail++; $display("FAIL sl_store_pulse got=not_single exp=single"); end
    n_tests++; if (store_count !== exp_st_cnt) begin n_fail++; $display("FAIL sl_store_count got=%0d exp=%0d", store_count, exp_st_cnt); end
    model_apply(4'd4, 32'h40, '0);
    drive_txn(4'd4, 32'h40, '0, lat, rd, single);
    n_tests++; if (!lat_ok(lat)) begin n_fail++; $display("FAIL sl_load_latency got=%0d exp=%0d", lat, LAT); end
    n_tests++; if (rd !== exp_q.pop_front()) begin n_fail++; $display("FAIL sl_load_data got=%h exp=%h", rd, d); end
    n_tests++; if (load_count !== exp_ld_cnt) begin n_fail++; $display("FAIL sl_load_count got=%0d exp=%0d", load_count, exp_ld_cnt); end
  endtask

  task automatic test_wrap();
    int lat; logic [DW-1:0] rd; bit single;
    logic [DW-1:0] d;
    logic [AW-1:0] a2;
    d  = rand_line();
    a2 = 32'h40 + (32'd1 << (LG_DEPTH + LG_CL));
    model_apply(4'd7, 32'h40, d);
    drive_txn(4'd7, 32'h40, d, lat, rd, single);
    model_apply(4'd4, a2, '0);
    drive_txn(4'd4, a2, '0, lat, rd, single);
    n_tests++; if (rd !== exp_q.pop_front()) begin n_fail++; $display("FAIL wrap_data got=%h exp=%h", rd, d); end
  endtask

  task automatic test_bad_opcode();
    int lat; logic [DW-1:0] rd; bit single;
    logic [63:0] ld0, st0;
    ld0 = exp_ld_cnt; st0 = exp_st_cnt;
    model_apply(4'd3, 32'h40, rand_line());
    drive_txn(4'd3, 32'h40, rand_line(), lat, rd, single);
    n_tests++; if (!lat_ok(lat)) begin n_fail++; $display("FAIL badop_latency got=%0d exp=%0d", lat, LAT); end
    n_tests++; if (!single) begin n_fail++; $display("FAIL badop_pulse got=not_single exp=single"); end
    n_tests++; if (rd !== exp_last_load) begin n_fail++; $display("FAIL badop_hold got=%h exp=%h", rd, exp_last_load); end
    n_tests++; if (load_count !== ld0 || store_count !== st0) begin n_fail++; $display("FAIL badop_counts got=%0d/%0d exp=%0d/%0d", load_count, store_count, ld0, st0); end
    model_apply(4'd4, 32'h40, '0);
    drive_txn(4'd4, 32'h40, '0, lat, rd, single);
    n_tests++; if (rd !== exp_q.pop_front()) begin n_fail++; $display("FAIL badop_ram got=%h exp=%h", rd, exp_last_load); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [DW-1:0] rd; bit single;
    int pulses;
    pulses = 0;
    mem_req_valid  = 1'b1;
    mem_req_opcode = 4'd4;
    mem_req_addr   = 32'h40;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    mem_req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_rsp_valid) pulses++;
    end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL abort_pulses got=%0d exp=0", pulses); end
    n_tests++; if (load_count !== 64'd0 || store_count !== 64'd0) begin n_fail++; $display("FAIL abort_counts got=%0d/%0d exp=0/0", load_count, store_count); end
    n_tests++; if (mem_rsp_load_data !== '0) begin n_fail++; $display("FAIL abort_load_data got=%h exp=0", mem_rsp_load_data); end
    model_apply(4'd4, 32'h40, '0);
    drive_txn(4'd4, 32'h40, '0, lat, rd, single);
    n_tests++; if (!lat_ok(lat) || rd !== exp_q.pop_front()) begin n_fail++; $display("FAIL abort_recover got=lat%0d/%h exp=lat%0d/%h", lat, rd, LAT, exp_last_load); end
    n_tests++; if (load_count !== exp_ld_cnt) begin n_fail++; $display("FAIL abort_recover_count got=%0d exp=%0d", load_count, exp_ld_cnt); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [DW-1:0] rd; bit single;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    d = rand_line();
    a = mk_addr($urandom_range(16, 31));
    model_apply(4'd7, a, d);
    drive_txn(4'd7, a, d, lat, rd, single);
    n_tests++; if (rd !== exp_last_load) begin n_fail++; $display("FAIL b2b_hold got=%h exp=%h", rd, exp_last_load); end
    model_apply(4'd4, a, '0);
    drive_txn(4'd4, a, '0, lat, rd, single);
    n_tests++; if (!lat_ok(lat) || rd !== exp_q.pop_front()) begin n_fail++; $display("FAIL b2b_load got=lat%0d/%h exp=lat%0d/%h", lat, rd, LAT, d); end
  endtask

  task automatic test_random();
    int lat; logic [DW-1:0] rd; bit single;
    int written [$];
    logic [3:0] op;
    logic [AW-1:0] a;
    logic [DW-1:0] d, e;
    int idx, sel;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4 || written.size() == 0) begin
        op = 4'd7; idx = $urandom_range(100, 115);
        written.push_back(idx);
      end else if (sel < 8) begin
        op = 4'd4; idx = written[$urandom_range(0, written.size() - 1)];
      end else begin
        do op = 4'($urandom_range(0, 15)); while (op == 4'd4 || op == 4'd7);
        idx = $urandom_range(100, 115);
      end
      a = mk_addr(idx);
      d = rand_line();
      model_apply(op, a, d);
      drive_txn(op, a, d, lat, rd, single);
      n_tests++; if (!lat_ok(lat) || !single) begin n_fail++; $display("FAIL rnd_timing n=%0d op=%0d got=lat%0d/single%0b exp=lat%0d/single1", n, op, lat, single, LAT); end
      e = (op == 4'd4) ? exp_q.pop_front() : exp_last_load;
      n_tests++; if (rd !== e) begin n_fail++; $display("FAIL rnd_data n=%0d op=%0d got=%h exp=%h", n, op, rd, e); end
      n_tests++; if (load_count !== exp_ld_cnt || store_count !== exp_st_cnt) begin n_fail++; $display("FAIL rnd_counts n=%0d got=%0d/%0d exp=%0d/%0d", n, load_count, store_count, exp_ld_cnt, exp_st_cnt); end
    end
  endtask

  // Latency sequence after reset must be reproducible and in range.
  task automatic test_latency_repeat();
    int lat; logic [DW-1:0] rd; bit single;
    int seq_a [32];
    int bad_range, bad_repeat;
    bad_range = 0; bad_repeat = 0;
    for (int run = 0; run < 2; run++) begin
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int n = 0; n < 32; n++) begin
        drive_txn(4'd4, 32'h40, '0, lat, rd, single);
        if (!lat_ok(lat)) bad_range++;
        if (run == 0) seq_a[n] = lat;
        else if (seq_a[n] != lat) bad_repeat++;
      end
    end
    n_tests++; if (bad_range != 0) begin n_fail++; $display("FAIL lat_range got=%0d_out_of_range exp=0", bad_range); end
    n_tests++; if (bad_repeat != 0) begin n_fail++; $display("FAIL lat_repeat got=%0d_differences exp=0", bad_repeat); end
    n_tests++; if (load_count !== 64'd32) begin n_fail++; $display("FAIL lat_load_count got=%0d exp=32", load_count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_store_load();
    test_wrap();
    test_bad_opcode();
    test_reset_abort();
    test_back_to_back();
    test_random();
    test_latency_repeat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
